// File: rtl/dcache_tlc_prot_pkg.sv
// Shared types and helpers for the dcache TL-C channel-C protection tagger.
//   tlc_bits_t   : TL-C channel C beat (opcode, param, size, source, address, data, corrupt)
//   amba_prot_t  : 7-bit AMBA protection attributes attached to each outgoing beat
//   tlc_opcode_e : channel-C opcodes
//   beat_lg()    : log2 of the beat width in bytes
//   is_data_op() : opcode carries data beats (ProbeAckData / ReleaseData)
//   is_probe_op(): opcode answers a probe (ProbeAck / ProbeAckData)
// The field widths of tlc_bits_t are fixed here; the top-level parameters must
// agree with them.
package dcache_tlc_prot_pkg;

    localparam int TLC_DATA_W   = 64;
    localparam int TLC_ADDR_W   = 32;
    localparam int TLC_SOURCE_W = 4;

    // Wide enough for the longest burst size[3:0] can describe at one byte per beat.
    localparam int BEAT_CNT_W = 16;

    typedef enum logic [2:0] {
        TLC_PROBE_ACK        = 3'd4,
        TLC_PROBE_ACK_DATA   = 3'd5,
        TLC_RELEASE          = 3'd6,
        TLC_RELEASE_DATA     = 3'd7
    } tlc_opcode_e;

    typedef struct packed {
        logic [2:0]              opcode;
        logic [2:0]              param;
        logic [3:0]              size;
        logic [TLC_SOURCE_W-1:0] source;
        logic [TLC_ADDR_W-1:0]   address;
        logic [TLC_DATA_W-1:0]   data;
        logic                    corrupt;
    } tlc_bits_t;

    typedef struct packed {
        logic bufferable;
        logic modifiable;
        logic readalloc;
        logic writealloc;
        logic privileged;
        logic secure;
        logic fetch;
    } amba_prot_t;

    function automatic int beat_lg(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic is_data_op(input logic [2:0] op);
        return (op == TLC_PROBE_ACK_DATA) || (op == TLC_RELEASE_DATA);
    endfunction

    function automatic logic is_probe_op(input logic [2:0] op);
        return (op == TLC_PROBE_ACK) || (op == TLC_PROBE_ACK_DATA);
    endfunction

endpackage

// File: rtl/dcache_tlc_beat_counter.sv
// Tracks the position of each accepted beat inside its TL-C burst.
//   clock, reset : clock and asynchronous active-high reset
//   fire         : a beat is accepted this cycle
//   opcode, size : opcode and size of the beat currently presented
//   first        : presented beat is the first of a burst
//   last         : presented beat is the last of a burst
module dcache_tlc_beat_counter
    import dcache_tlc_prot_pkg::*;
#(
    parameter int DATA_W = TLC_DATA_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fire,
    input  logic [2:0] opcode,
    input  logic [3:0] size,
    output logic       first,
    output logic       last
);

    localparam int BEAT_LG = beat_lg(DATA_W);
    localparam logic [BEAT_CNT_W-1:0] CNT_ONE = BEAT_CNT_W'(1);

    logic [BEAT_CNT_W-1:0] count;
    logic [BEAT_CNT_W-1:0] final_idx;

    // Index of the last beat: 2^(size-BEAT_LG)-1 for multi-beat data bursts, else 0.
    always_comb begin
        final_idx = '0;
        if (is_data_op(opcode) && (int'(size) > BEAT_LG)) begin
            final_idx = (CNT_ONE << (int'(size) - BEAT_LG)) - CNT_ONE;
        end
    end

    assign first = (count == '0);
    assign last  = (count == final_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (fire) begin
            count <= last ? '0 : count + CNT_ONE;
        end
    end

endmodule

// File: rtl/dcache_tlc_prot_tagger.sv
// Registers the dcache TL-C channel-C stream and attaches AMBA protection
// attributes sampled on the first beat of each burst.
//   clock, reset                     : clock and asynchronous active-high reset
//   c_in_valid/c_in_ready/c_in_bits  : upstream beats from the release/probe unit
//   prot_privileged_i/_secure_i/_cacheable_i : core mode and PMA sideband
//   c_out_valid/c_out_ready/c_out_bits : downstream beats, one cycle after acceptance
//   c_out_prot                       : protection attributes of the outgoing beat
//   err_o                            : sticky protocol-error flag
// Optional feature: define SIFIVE_DCACHE_TLC_PROT_CHECK_EN to enable the burst
// consistency and alignment checker; otherwise err_o is tied low.
module dcache_tlc_prot_tagger
    import dcache_tlc_prot_pkg::*;
#(
    parameter int DATA_W   = TLC_DATA_W,
    parameter int ADDR_W   = TLC_ADDR_W,
    parameter int SOURCE_W = TLC_SOURCE_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       c_in_valid,
    output logic       c_in_ready,
    input  tlc_bits_t  c_in_bits,
    input  logic       prot_privileged_i,
    input  logic       prot_secure_i,
    input  logic       prot_cacheable_i,
    output logic       c_out_valid,
    input  logic       c_out_ready,
    output tlc_bits_t  c_out_bits,
    output amba_prot_t c_out_prot,
    output logic       err_o
);

    // The beat struct has fixed field widths; refuse mismatched parameters.
    if (DATA_W != TLC_DATA_W || ADDR_W != TLC_ADDR_W || SOURCE_W != TLC_SOURCE_W) begin : g_width_check
        $error("dcache_tlc_prot_tagger: parameters must match dcache_tlc_prot_pkg field widths");
    end

    logic       fire;
    logic       first;
    logic       last;
    amba_prot_t new_prot;

    // The output register can take a new beat when empty or draining this cycle.
    assign c_in_ready = !c_out_valid || c_out_ready;
    assign fire       = c_in_valid && c_in_ready;

    dcache_tlc_beat_counter #(
        .DATA_W (DATA_W)
    ) u_beat_counter (
        .clock  (clock),
        .reset  (reset),
        .fire   (fire),
        .opcode (c_in_bits.opcode),
        .size   (c_in_bits.size),
        .first  (first),
        .last   (last)
    );

    // Probe responses always go out as privileged secure traffic.
    always_comb begin
        new_prot            = '0;
        new_prot.bufferable = prot_cacheable_i;
        new_prot.modifiable = prot_cacheable_i;
        new_prot.readalloc  = prot_cacheable_i;
        new_prot.writealloc = prot_cacheable_i;
        new_prot.privileged = prot_privileged_i || is_probe_op(c_in_bits.opcode);
        new_prot.secure     = prot_secure_i || is_probe_op(c_in_bits.opcode);
        new_prot.fetch      = 1'b0;
    end

    // c_out_prot is only rewritten on a first beat, so later beats of the
    // burst inherit the attributes sampled at its start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_out_valid <= 1'b0;
            c_out_bits  <= '0;
            c_out_prot  <= '0;
        end else if (fire) begin
            c_out_valid <= 1'b1;
            c_out_bits  <= c_in_bits;
            if (first) begin
                c_out_prot <= new_prot;
            end
        end else if (c_out_ready) begin
            c_out_valid <= 1'b0;
        end
    end

`ifdef SIFIVE_DCACHE_TLC_PROT_CHECK_EN
    logic [2:0]              ref_opcode;
    logic [3:0]              ref_size;
    logic [TLC_SOURCE_W-1:0] ref_source;
    logic                    misaligned;
    logic                    mismatch;

    assign misaligned = (c_in_bits.address &
                         ((TLC_ADDR_W'(1) << c_in_bits.size) - TLC_ADDR_W'(1))) != '0;
    assign mismatch   = (c_in_bits.opcode != ref_opcode) ||
                        (c_in_bits.size   != ref_size)   ||
                        (c_in_bits.source != ref_source);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_opcode <= '0;
            ref_size   <= '0;
            ref_source <= '0;
            err_o      <= 1'b0;
        end else if (fire) begin
            if (first) begin
                ref_opcode <= c_in_bits.opcode;
                ref_size   <= c_in_bits.size;
                ref_source <= c_in_bits.source;
            end
            err_o <= err_o || (first ? misaligned : mismatch);
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
